// File: rtl/psum_ofifo_pkg.sv
// ----------------------------------------------------------------------------
// psum_ofifo_pkg
// Shared constants for the MAC-array output collector.
//   COL         : default number of array columns (one FIFO lane each)
//   PSUM_BW     : default partial-sum width per column
//   OFIFO_DEPTH : default entries per column lane (power of 2, >= 2)
//   PTR_W/ptr_t : lane pointer width, log2(depth) address bits plus a wrap bit
// ----------------------------------------------------------------------------
package psum_ofifo_pkg;

    localparam int COL         = 8;
    localparam int PSUM_BW     = 16;
    localparam int OFIFO_DEPTH = 64;

    // Pointer width for a lane of a given depth: address bits plus one wrap bit
    function automatic int ptrWidth(input int depthIn);
        return $clog2(depthIn) + 1;
    endfunction

    localparam int PTR_W = ptrWidth(OFIFO_DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/psum_ofifo_lane.sv
// ----------------------------------------------------------------------------
// psum_fifo_lane
// One column of the output collector: a depth x psum_bw circular FIFO with a
// show-ahead head output.
//   clk, reset : clock and asynchronous active-high reset
//   wr         : write request for din
//   pop        : advance the read pointer (head already presented on dout)
//   din        : data to store
//   dout       : current head entry (show-ahead)
//   empty      : lane holds no entries
//   full       : lane holds depth entries
//   drop       : a write arrived while full with no pop to make room
// ----------------------------------------------------------------------------
module psum_fifo_lane
    import psum_ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               pop,
    input  logic [psum_bw-1:0] din,
    output logic [psum_bw-1:0] dout,
    output logic               empty,
    output logic               full,
    output logic               drop
);

    localparam int PW = ptrWidth(depth);
    localparam int AW = PW - 1;

    logic [PW-1:0]      r_wrPtr;
    logic [PW-1:0]      r_rdPtr;
    logic [psum_bw-1:0] r_mem [depth];
    logic               w_wrAccept;
    logic               w_rdAdvance;

    // Equal pointers mean empty; equal address bits with opposite wrap bits
    // mean the writer is exactly one lap ahead, i.e. full.
    assign empty = (r_wrPtr == r_rdPtr);
    assign full  = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) &&
                   (r_wrPtr[AW] != r_rdPtr[AW]);

    // A write into a full lane is still safe when the same edge pops, because
    // the slot being overwritten is the head that is leaving this cycle.
    assign w_wrAccept  = wr && (!full || pop);
    assign drop        = wr && full && !pop;
    assign w_rdAdvance = pop && !empty;

    assign dout = r_mem[r_rdPtr[AW-1:0]];

    // Pointer update; both pointers free-run modulo 2*depth so the wrap bit
    // alone distinguishes full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_wrAccept) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_rdAdvance) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    // Storage array; contents are don't-care after reset so it has no reset.
    always_ff @(posedge clk) begin
        if (w_wrAccept) begin
            r_mem[r_wrPtr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/psum_ofifo.sv
// ----------------------------------------------------------------------------
// psum_ofifo
// Output-side collector for the MAC array. Buffers each column's partial sums
// in its own lane, and releases one aligned row per read handshake.
//   clk, reset : clock and asynchronous active-high reset
//   in         : packed partial sums, column c at [psum_bw*(c+1)-1 : psum_bw*c]
//   wr         : per-column write strobes (array valid)
//   rd         : request to pop one aligned row
//   out        : registered popped row, same packing as in
//   out_vld    : one-cycle pulse marking a freshly popped row on out
//   o_valid    : every lane non-empty, a full row is available
//   o_full     : at least one lane is full
//   o_empty    : every lane is empty
//   overflow   : sticky, set when any write was dropped
// ----------------------------------------------------------------------------
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   out_vld,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   overflow
);

    logic [psum_bw*col-1:0] w_head;
    logic [col-1:0]         w_empty;
    logic [col-1:0]         w_full;
    logic [col-1:0]         w_drop;
    logic                   w_pop;

    logic [psum_bw*col-1:0] r_out;
    logic                   r_outVld;
    logic                   r_overflow;

    // One independent lane per column. Skew between columns needs no special
    // handling: a row is only poppable once its last column has landed.
    for (genvar c = 0; c < col; c++) begin : g_lane
        psum_fifo_lane #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[c]),
            .pop   (w_pop),
            .din   (in[psum_bw*c +: psum_bw]),
            .dout  (w_head[psum_bw*c +: psum_bw]),
            .empty (w_empty[c]),
            .full  (w_full[c]),
            .drop  (w_drop[c])
        );
    end

    // Row-level status is a reduction across lanes; a pop needs every lane
    // to hold at least one entry, so all read pointers always move together.
    assign o_valid = ~|w_empty;
    assign o_empty = &w_empty;
    assign o_full  = |w_full;
    assign w_pop   = rd && o_valid;

    // Output row register: captures the lane heads on a pop and holds them
    // otherwise; the valid pulse lasts exactly one cycle per pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out    <= '0;
            r_outVld <= 1'b0;
        end else begin
            r_outVld <= w_pop;
            if (w_pop) begin
                r_out <= w_head;
            end
        end
    end

    // Sticky drop indicator; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (|w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign out      = r_out;
    assign out_vld  = r_outVld;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_psum_ofifo.sv
// ----------------------------------------------------------------------------
// tb_psum_ofifo
// Directed bench for psum_ofifo. Stimulus pushes the hand-computed row it
// expects whenever it issues a pop; a monitor pops and compares on every
// out_vld. Flag checks are made directly after the relevant clock edge.
// ----------------------------------------------------------------------------
module tb_psum_ofifo;

    localparam int COLS = 8;
    localparam int BW   = 16;
    localparam int DEP  = 64;
    localparam int RW   = COLS * BW;

    logic          clk;
    logic          reset;
    logic [RW-1:0] in;
    logic [COLS-1:0] wr;
    logic          rd;
    logic [RW-1:0] out;
    logic          out_vld;
    logic          o_valid;
    logic          o_full;
    logic          o_empty;
    logic          overflow;

    int            checks;
    int            errors;
    logic [RW-1:0] expQ [$];

    psum_ofifo #(
        .col     (COLS),
        .psum_bw (BW),
        .depth   (DEP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .wr       (wr),
        .rd       (rd),
        .out      (out),
        .out_vld  (out_vld),
        .o_valid  (o_valid),
        .o_full   (o_full),
        .o_empty  (o_empty),
        .overflow (overflow)
    );

    // Free-running clock, active edge is posedge
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Row whose column c holds base + c, so lane ordering errors show up
    function automatic logic [RW-1:0] mkRow(input logic [15:0] base);
        logic [RW-1:0] r;
        r = '0;
        for (int c = 0; c < COLS; c++) begin
            r[BW*c +: BW] = base + 16'(c);
        end
        return r;
    endfunction

    // Drive one cycle of inputs at the falling edge, let the rising edge
    // sample them, then return just after that edge with inputs idle.
    task automatic applyStimulus(input logic [COLS-1:0] w, input logic [RW-1:0] d,
                                 input logic r);
        @(negedge clk);
        wr = w;
        in = d;
        rd = r;
        @(posedge clk);
        #1;
        wr = '0;
        rd = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [RW-1:0] act,
                               input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pop a row while expecting a specific value to appear on out
    task automatic popExpect(input logic [RW-1:0] row);
        expQ.push_back(row);
        applyStimulus('0, '0, 1'b1);
    endtask

    // Give the monitor time to consume, then confirm nothing is outstanding
    task automatic checkDrained(input string name);
        repeat (3) @(negedge clk);
        checkOutput(name, RW'(expQ.size()), RW'(0));
        expQ.delete();
    endtask

    task automatic pulseReset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1 reset = 1'b0;
    endtask

    // Scoreboard monitor: every presented row must match the oldest expected
    always @(negedge clk) begin
        if (!reset && out_vld === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL rowUnexpected: got %h expected no row", out);
            end else begin
                logic [RW-1:0] e;
                e = expQ.pop_front();
                if (out !== e) begin
                    errors++;
                    $display("[TB] FAIL rowData: got %h expected %h", out, e);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        wr     = '0;
        rd     = 1'b0;
        in     = '0;
        #12 reset = 1'b0;

        // Asynchronous reset mid-cycle with a held row on out
        applyStimulus(8'hFF, mkRow(16'hA000), 1'b0);
        applyStimulus(8'hFF, mkRow(16'hB000), 1'b0);
        popExpect(mkRow(16'hA000));
        @(negedge clk);
        #1;
        checkOutput("outHeldBeforeReset", out, mkRow(16'hA000));
        reset = 1'b1;
        #1;
        checkOutput("rstOut", out, '0);
        checkOutput("rstOutVld", RW'(out_vld), RW'(0));
        checkOutput("rstEmpty", RW'(o_empty), RW'(1));
        checkOutput("rstValid", RW'(o_valid), RW'(0));
        checkOutput("rstOverflow", RW'(overflow), RW'(0));
        checkOutput("rstFull", RW'(o_full), RW'(0));
        reset = 1'b0;
        checkDrained("rstDrained");

        // Skewed row: column c written on cycle c
        for (int c = 0; c < COLS; c++) begin
            applyStimulus(COLS'(1) << c, mkRow(16'h0100), 1'b0);
            checkOutput($sformatf("skewValid%0d", c), RW'(o_valid), RW'(c == COLS - 1));
        end
        popExpect(mkRow(16'h0100));
        checkOutput("skewEmpty", RW'(o_empty), RW'(1));
        applyStimulus('0, '0, 1'b0);
        checkOutput("skewVldPulse", RW'(out_vld), RW'(0));
        checkOutput("skewOutHold", out, mkRow(16'h0100));
        checkDrained("skewDrained");

        // Fill every lane, then one more row must be dropped
        for (int v = 0; v < DEP; v++) begin
            applyStimulus(8'hFF, {COLS{16'(v)}}, 1'b0);
        end
        checkOutput("fillFull", RW'(o_full), RW'(1));
        checkOutput("fillNoOvf", RW'(overflow), RW'(0));
        applyStimulus(8'hFF, {COLS{16'd99}}, 1'b0);
        checkOutput("ovfSet", RW'(overflow), RW'(1));
        checkOutput("ovfFull", RW'(o_full), RW'(1));
        for (int v = 0; v < DEP; v++) begin
            popExpect({COLS{16'(v)}});
        end
        checkOutput("fillEmpty", RW'(o_empty), RW'(1));
        checkOutput("ovfSticky", RW'(overflow), RW'(1));

        // Read while nothing is available is ignored
        applyStimulus('0, '0, 1'b1);
        checkOutput("idleRdVld", RW'(out_vld), RW'(0));
        checkOutput("idleRdOut", out, {COLS{16'd63}});
        checkDrained("fillDrained");
        pulseReset();
        #1;
        checkOutput("ovfCleared", RW'(overflow), RW'(0));

        // Full lanes with a simultaneous write and pop
        for (int v = 0; v < DEP; v++) begin
            applyStimulus(8'hFF, mkRow(16'h0200 + 16'(v * 16)), 1'b0);
        end
        expQ.push_back(mkRow(16'h0200));
        applyStimulus(8'hFF, mkRow(16'h7000), 1'b1);
        checkOutput("fullPopNoOvf", RW'(overflow), RW'(0));
        checkOutput("fullPopFull", RW'(o_full), RW'(1));
        for (int v = 1; v < DEP; v++) begin
            popExpect(mkRow(16'h0200 + 16'(v * 16)));
        end
        popExpect(mkRow(16'h7000));
        checkOutput("fullPopEmpty", RW'(o_empty), RW'(1));
        checkDrained("fullPopDrained");

        // Streaming across several pointer laps with occupancy held at 2-3
        applyStimulus(8'hFF, mkRow(16'h1000), 1'b0);
        applyStimulus(8'hFF, mkRow(16'h1010), 1'b0);
        for (int i = 2; i < 200; i++) begin
            expQ.push_back(mkRow(16'h1000 + 16'((i - 2) * 16)));
            applyStimulus(8'hFF, mkRow(16'h1000 + 16'(i * 16)), 1'b1);
        end
        popExpect(mkRow(16'h1000 + 16'(198 * 16)));
        popExpect(mkRow(16'h1000 + 16'(199 * 16)));
        checkOutput("wrapNoOvf", RW'(overflow), RW'(0));
        checkOutput("wrapEmpty", RW'(o_empty), RW'(1));
        checkDrained("wrapDrained");

        // Reset in the middle of a stream discards buffered rows
        for (int k = 0; k < 5; k++) begin
            applyStimulus(8'hFF, mkRow(16'h5000 + 16'(k * 16)), 1'b0);
        end
        pulseReset();
        #1;
        checkOutput("midRstEmpty", RW'(o_empty), RW'(1));
        checkOutput("midRstValid", RW'(o_valid), RW'(0));
        applyStimulus(8'hFF, mkRow(16'h6000), 1'b0);
        applyStimulus(8'hFF, mkRow(16'h6010), 1'b0);
        popExpect(mkRow(16'h6000));
        popExpect(mkRow(16'h6010));
        checkOutput("postRstEmpty", RW'(o_empty), RW'(1));
        checkDrained("postRstDrained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/psum_ofifo.md
# psum_ofifo

Output-side collector for the MAC array. It takes the per-column partial sums that leave the bottom of the array, together with their per-column valid strobes. Because of the instruction skew, column c produces its valid one cycle after column c-1. The block buffers each column independently, realigns the columns into whole output rows, and releases one complete row per read handshake to the downstream SFU and memory write-back path.

## Interface

Parameters:
- `col`, 8: number of array columns (one FIFO lane per column).
- `psum_bw`, 16: partial-sum width per column.
- `depth`, 64: entries per column lane. Must be a power of 2 and at least 2.

Ports:
- `clk`, input, 1: single clock for the whole block.
- `reset`, input, 1: asynchronous, active-high.
- `in`, input, `psum_bw*col`: partial sums from the array's `out_s`. Column c occupies bits `[psum_bw*(c+1)-1 : psum_bw*c]`.
- `wr`, input, `col`: per-column write strobe, driven from the array's `valid`.
- `rd`, input, 1: request to pop one aligned row.
- `out`, output, `psum_bw*col`: registered aligned row, same column packing as `in`.
- `out_vld`, output, 1: `out` holds a freshly popped row. High for exactly one cycle per pop.
- `o_valid`, output, 1: every column lane is non-empty, so a full row is available.
- `o_full`, output, 1: at least one column lane is full.
- `o_empty`, output, 1: every column lane is empty.
- `overflow`, output, 1: sticky flag, set when a write was dropped. Cleared only by `reset`.

## Operation

- Each column lane is an independent circular FIFO of `depth` entries, `psum_bw` bits wide.
- Each lane has a write pointer and a read pointer, each `log2(depth)+1` bits wide. The MSB is the wrap bit.
  - Lane empty: pointers are equal.
  - Lane full: low bits are equal and wrap bits differ.
- **Write:** when `wr[c]` is 1, the lane-c slice of `in` is written at the lane-c write pointer, and that pointer increments (modulo `2*depth`).
  - Lanes write independently, so any subset of `wr` bits may be high in a cycle.
- **Write to a full lane:**
  - If the same cycle performs a pop (`rd && o_valid`), the write is accepted.
  - Otherwise the write is dropped, the pointer holds, and `overflow` sets.
- **Pop:** occurs when `rd && o_valid`.
  - All `col` read pointers increment together.
  - The concatenated lane heads load into `out`.
  - `out_vld` is 1 on the following cycle.
- **`rd` while `o_valid` is 0:** ignored. No pointer moves, `out` holds its value, and `out_vld` is 0.
- `o_valid`, `o_full` and `o_empty` are combinational from the pointers.
- Rows are assembled purely by lane order. Skew between columns is absorbed because a row becomes poppable only once its last column has been written.
- No arithmetic is done on the data: values are stored and returned bit-exact.

## Timing

- **Reset values:** all pointers 0, `out` = 0, `out_vld` = 0, `overflow` = 0, `o_empty` = 1, `o_valid` = 0, `o_full` = 0. Storage contents are don't-care.
- **Write-to-visible latency:** a write at edge N updates the flags after edge N.
  - For a skewed row whose last column (col-1) is written at edge N, `o_valid` rises after edge N.
- **Pop latency:** with `rd && o_valid` sampled at edge N, `out` and `out_vld` are valid after edge N and held for one cycle. `out` then holds until the next pop.
- **Back-to-back pops** are allowed every cycle while `o_valid` stays high.
- **Simultaneous write and pop on a non-full lane:** both take effect and the occupancy is unchanged.
- **Write and pop on an empty lane in the same cycle:** no pop occurs, because `o_valid` is 0. The write is accepted.
- **Reset mid-operation:** immediately clears pointers, flags, `out` and `out_vld`. In-flight data is lost.
- **Pointer wrap:** correct across any number of laps. Full and empty are distinguished by the wrap bit only.

## Structure

- Shared package holds:
  - `COL`, `PSUM_BW`, `OFIFO_DEPTH` default constants.
  - A `ptr_t` width constant, `$clog2(depth)+1`.
- Single sub-module: `psum_fifo_lane`. It is one column's depth×`psum_bw` FIFO with ports `wr`, `pop`, `din`, `dout` (head, show-ahead), `empty`, `full`, and a drop indication.
- The top module instantiates `col` lanes in a generate loop and contains:
  - AND/OR reduction for `o_valid`, `o_full` and `o_empty`.
  - The pop qualification `rd && o_valid`.
  - The `out`/`out_vld` register.
  - The `overflow` sticky register.

## Test plan

- **Reset:** assert `reset` asynchronously mid-cycle.
  - Expect: `out` = 0, `out_vld` = 0, `o_empty` = 1, `o_valid` = 0, `overflow` = 0 without waiting for a clock edge.
- **Skewed row:** write lane c = 16'h0100+c at cycle c, for c = 0..7.
  - Expect: `o_valid` is 0 through cycle 6 and 1 after cycle 7.
  - Then `rd` = 1 → `out` = {16'h0107, …, 16'h0100}, `out_vld` high for one cycle, `o_empty` = 1.
- **Fill and overflow:** write 64 aligned rows with values 0..63 and no reads, then a 65th row with value 99.
  - Expect: `o_full` = 1, `overflow` = 1.
  - Popping 64 rows returns 0..63 in order and 99 never appears.
- **Wrap:** stream 200 rows with write and `rd` concurrent, occupancy kept between 1 and 3.
  - Expect: all 200 rows popped in order, `overflow` = 0, pointers wrapping at least 3 times.
- **Full with pop:** with all lanes full, assert `wr` = 8'hFF and `rd` = 1 in the same cycle.
  - Expect: the write is accepted, `overflow` = 0, `o_full` stays 1.
  - `out` gets the oldest row, and the new row is returned 64 pops later.
- **Reset mid-stream:** after 5 writes, pulse `reset`.
  - Expect: `o_empty` = 1 and `o_valid` = 0.
  - Expect: subsequent writes are returned starting from the first post-reset value.
